// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sa_pkg
//  Purpose  : Shared definitions for the output-stationary systolic array:
//             array geometry, tile-scheduler state encoding and the tile
//             command record used by the scheduler, feeder and drain blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package sa_pkg;

    // Array geometry: P rows (M and N tile limit), Q columns (L tile limit).
    localparam int P     = 8;
    localparam int Q     = 8;
    localparam int DIM_W = 8;

    // Scheduler state encoding.
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] c_ST_SETUP = 2'd1;
    localparam logic [ST_W-1:0] c_ST_ISSUE = 2'd2;
    localparam logic [ST_W-1:0] c_ST_FIN   = 2'd3;

    // One tile command as seen by the feeder and drain logic.
    typedef struct packed {
        logic [DIM_W-1:0] m_off;
        logic [DIM_W-1:0] n_off;
        logic [DIM_W-1:0] l_off;
        logic [DIM_W-1:0] m_size;
        logic [DIM_W-1:0] n_size;
        logic [DIM_W-1:0] l_size;
        logic             acc_clr;
        logic             wb;
        logic             last;
    } tile_cmd_t;

endpackage
`default_nettype wire

// File: rtl/sa_tile_divider.sv
`default_nettype none
// ============================================================================
//  Module   : sa_tile_divider
//  Purpose  : Balanced partition of one matrix dimension. Counts tiles as
//             ceil(dim/limit) by repeated subtraction, then splits dim into
//             base = dim/cnt and remx = dim%cnt, also by repeated subtraction.
//  Revision : 1.0 - initial release
// ============================================================================
module sa_tile_divider #(
    parameter int DIM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] dim,
    input  logic [DIM_W-1:0] limit,
    output logic [DIM_W-1:0] cnt,
    output logic [DIM_W-1:0] base,
    output logic [DIM_W-1:0] remx,
    output logic             ready
);

    localparam logic [1:0]       c_DV_IDLE  = 2'd0;
    localparam logic [1:0]       c_DV_COUNT = 2'd1;
    localparam logic [1:0]       c_DV_SPLIT = 2'd2;
    localparam logic [1:0]       c_DV_DONE  = 2'd3;
    localparam logic [DIM_W-1:0] c_ONE      = DIM_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [DIM_W-1:0] r_dim;
    logic [DIM_W-1:0] r_rem;
    logic [DIM_W-1:0] r_cnt;
    logic [DIM_W-1:0] r_base;
    logic [DIM_W-1:0] r_remx;
    logic             r_ready;
    logic [DIM_W-1:0] w_step;
    logic             w_split_end;

    // Each counting step removes one full tile, or whatever is left.
    assign w_step      = (r_rem < limit) ? r_rem : limit;
    // A zero count can only come from a zero dim; finish rather than spin.
    assign w_split_end = (r_cnt == '0) || (r_rem < r_cnt);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_DV_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state: count phase, then split phase, then hold results.
    always_comb begin
        w_state_nx = r_state;
        if (start) begin
            w_state_nx = c_DV_COUNT;
        end else begin
            case (r_state)
                c_DV_COUNT: if (r_rem == '0) w_state_nx = c_DV_SPLIT;
                c_DV_SPLIT: if (w_split_end) w_state_nx = c_DV_DONE;
                default:    w_state_nx = r_state;
            endcase
        end
    end

    // Subtract-based datapath; a start pulse restarts from the new dim.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dim   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_base  <= '0;
            r_remx  <= '0;
            r_ready <= 1'b0;
        end else if (start) begin
            r_dim   <= dim;
            r_rem   <= dim;
            r_cnt   <= '0;
            r_base  <= '0;
            r_remx  <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                c_DV_COUNT: begin
                    if (r_rem == '0) begin
                        r_rem <= r_dim;
                    end else begin
                        r_rem <= r_rem - w_step;
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                c_DV_SPLIT: begin
                    if (w_split_end) begin
                        r_remx  <= r_rem;
                        r_ready <= 1'b1;
                    end else begin
                        r_rem  <= r_rem - r_cnt;
                        r_base <= r_base + c_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt   = r_cnt;
    assign base  = r_base;
    assign remx  = r_remx;
    assign ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/sa_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sa_tile_scheduler
//  Purpose  : Tile sequencer for the PxQ output-stationary systolic array.
//             Partitions M, N, L into balanced tiles and issues one command
//             per (m,l,n) tile, n innermost, over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module sa_tile_scheduler #(
    parameter int P     = sa_pkg::P,
    parameter int Q     = sa_pkg::Q,
    parameter int DIM_W = sa_pkg::DIM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_m,
    input  logic [DIM_W-1:0] cfg_n,
    input  logic [DIM_W-1:0] cfg_l,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [DIM_W-1:0] cmd_m_off,
    output logic [DIM_W-1:0] cmd_n_off,
    output logic [DIM_W-1:0] cmd_l_off,
    output logic [DIM_W-1:0] cmd_m_size,
    output logic [DIM_W-1:0] cmd_n_size,
    output logic [DIM_W-1:0] cmd_l_size,
    output logic             cmd_acc_clr,
    output logic             cmd_wb,
    output logic             cmd_last
);

    import sa_pkg::*;

    localparam logic [DIM_W-1:0] c_ONE    = DIM_W'(1);
    localparam logic [DIM_W-1:0] c_LIM_MN = DIM_W'(P);
    localparam logic [DIM_W-1:0] c_LIM_L  = DIM_W'(Q);

    // Size of tile idx: the first remx tiles carry one extra element.
    function automatic logic [DIM_W-1:0] f_tile_size(
        input logic [DIM_W-1:0] b,
        input logic [DIM_W-1:0] rx,
        input logic [DIM_W-1:0] idx
    );
        f_tile_size = (idx < rx) ? (b + c_ONE) : b;
    endfunction

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nx;

    logic             w_accept;
    logic             w_cfg_zero;
    logic             w_div_start;
    logic             w_all_ready;
    logic             w_load_first;
    logic             w_hs;
    logic             w_advance;

    logic [DIM_W-1:0] w_cnt_m, w_cnt_n, w_cnt_l;
    logic [DIM_W-1:0] w_base_m, w_base_n, w_base_l;
    logic [DIM_W-1:0] w_remx_m, w_remx_n, w_remx_l;
    logic             w_rdy_m, w_rdy_n, w_rdy_l;

    logic [DIM_W-1:0] r_m_idx, r_n_idx, r_l_idx;
    logic [DIM_W-1:0] r_m_off, r_n_off, r_l_off;
    logic [DIM_W-1:0] r_m_size, r_n_size, r_l_size;
    logic             r_valid;
    logic             r_acc_clr;
    logic             r_wb;
    logic             r_last;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_err;

    logic             w_n_wrap, w_l_wrap;
    logic [DIM_W-1:0] w_m_idx_sel, w_n_idx_sel, w_l_idx_sel;
    logic [DIM_W-1:0] w_m_off_sel, w_n_off_sel, w_l_off_sel;

    assign w_accept     = (r_state == c_ST_IDLE) && start;
    assign w_cfg_zero   = (cfg_m == '0) || (cfg_n == '0) || (cfg_l == '0);
    assign w_div_start  = w_accept && !w_cfg_zero;
    assign w_all_ready  = w_rdy_m && w_rdy_n && w_rdy_l;
    assign w_load_first = (r_state == c_ST_SETUP) && w_all_ready;
    assign w_hs         = r_valid && cmd_ready;
    assign w_advance    = w_hs && !r_last;

    // The dividers latch the configuration on the accept edge.
    sa_tile_divider #(.DIM_W(DIM_W)) u_div_m (
        .clk(clk), .rst(rst), .start(w_div_start), .dim(cfg_m), .limit(c_LIM_MN),
        .cnt(w_cnt_m), .base(w_base_m), .remx(w_remx_m), .ready(w_rdy_m)
    );

    sa_tile_divider #(.DIM_W(DIM_W)) u_div_n (
        .clk(clk), .rst(rst), .start(w_div_start), .dim(cfg_n), .limit(c_LIM_MN),
        .cnt(w_cnt_n), .base(w_base_n), .remx(w_remx_n), .ready(w_rdy_n)
    );

    sa_tile_divider #(.DIM_W(DIM_W)) u_div_l (
        .clk(clk), .rst(rst), .start(w_div_start), .dim(cfg_l), .limit(c_LIM_L),
        .cnt(w_cnt_l), .base(w_base_l), .remx(w_remx_l), .ready(w_rdy_l)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state: IDLE -> SETUP -> ISSUE -> FIN -> IDLE.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_div_start)     w_state_nx = c_ST_SETUP;
            c_ST_SETUP: if (w_all_ready)     w_state_nx = c_ST_ISSUE;
            c_ST_ISSUE: if (w_hs && r_last)  w_state_nx = c_ST_FIN;
            c_ST_FIN:                        w_state_nx = c_ST_IDLE;
            default:                         w_state_nx = c_ST_IDLE;
        endcase
    end

    // Next tile position: n steps every handshake, l on n wrap, m on l wrap.
    // The first command of a job selects tile (0,0,0).
    always_comb begin
        w_n_wrap    = (r_n_idx == (w_cnt_n - c_ONE));
        w_l_wrap    = (r_l_idx == (w_cnt_l - c_ONE));

        w_n_idx_sel = w_n_wrap ? '0 : (r_n_idx + c_ONE);
        w_n_off_sel = w_n_wrap ? '0 : (r_n_off + r_n_size);

        w_l_idx_sel = r_l_idx;
        w_l_off_sel = r_l_off;
        if (w_n_wrap) begin
            w_l_idx_sel = w_l_wrap ? '0 : (r_l_idx + c_ONE);
            w_l_off_sel = w_l_wrap ? '0 : (r_l_off + r_l_size);
        end

        w_m_idx_sel = r_m_idx;
        w_m_off_sel = r_m_off;
        if (w_n_wrap && w_l_wrap) begin
            w_m_idx_sel = r_m_idx + c_ONE;
            w_m_off_sel = r_m_off + r_m_size;
        end

        if (w_load_first) begin
            w_m_idx_sel = '0;
            w_n_idx_sel = '0;
            w_l_idx_sel = '0;
            w_m_off_sel = '0;
            w_n_off_sel = '0;
            w_l_off_sel = '0;
        end
    end

    // Command payload, handshake and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_idx   <= '0;
            r_n_idx   <= '0;
            r_l_idx   <= '0;
            r_m_off   <= '0;
            r_n_off   <= '0;
            r_l_off   <= '0;
            r_m_size  <= '0;
            r_n_size  <= '0;
            r_l_size  <= '0;
            r_valid   <= 1'b0;
            r_acc_clr <= 1'b0;
            r_wb      <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && w_cfg_zero;
            r_done    <= w_hs && r_last;

            if (w_div_start) begin
                r_busy <= 1'b1;
            end else if (r_state == c_ST_FIN) begin
                r_busy <= 1'b0;
            end

            if (w_load_first || w_advance) begin
                r_m_idx   <= w_m_idx_sel;
                r_n_idx   <= w_n_idx_sel;
                r_l_idx   <= w_l_idx_sel;
                r_m_off   <= w_m_off_sel;
                r_n_off   <= w_n_off_sel;
                r_l_off   <= w_l_off_sel;
                r_m_size  <= f_tile_size(w_base_m, w_remx_m, w_m_idx_sel);
                r_n_size  <= f_tile_size(w_base_n, w_remx_n, w_n_idx_sel);
                r_l_size  <= f_tile_size(w_base_l, w_remx_l, w_l_idx_sel);
                r_acc_clr <= (w_n_idx_sel == '0);
                r_wb      <= (w_n_idx_sel == (w_cnt_n - c_ONE));
                r_last    <= (w_m_idx_sel == (w_cnt_m - c_ONE)) &&
                             (w_l_idx_sel == (w_cnt_l - c_ONE)) &&
                             (w_n_idx_sel == (w_cnt_n - c_ONE));
                r_valid   <= 1'b1;
            end else if (w_hs) begin
                r_valid   <= 1'b0;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_err     = r_cfg_err;
    assign cmd_valid   = r_valid;
    assign cmd_m_off   = r_m_off;
    assign cmd_n_off   = r_n_off;
    assign cmd_l_off   = r_l_off;
    assign cmd_m_size  = r_m_size;
    assign cmd_n_size  = r_n_size;
    assign cmd_l_size  = r_l_size;
    assign cmd_acc_clr = r_acc_clr;
    assign cmd_wb      = r_wb;
    assign cmd_last    = r_last;

endmodule
`default_nettype wire

// File: tb/tb_sa_tile_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sa_tile_scheduler
//  Purpose  : Scoreboard bench for sa_tile_scheduler. Expected commands come
//             from a closed-form partition model; a monitor pops and compares
//             on every handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sa_tile_scheduler;

    localparam int P     = 8;
    localparam int Q     = 8;
    localparam int DIM_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [DIM_W-1:0] cfg_m = '0;
    logic [DIM_W-1:0] cfg_n = '0;
    logic [DIM_W-1:0] cfg_l = '0;
    logic             cmd_ready = 1'b0;
    logic             busy, done, cfg_err, cmd_valid;
    logic [DIM_W-1:0] cmd_m_off, cmd_n_off, cmd_l_off;
    logic [DIM_W-1:0] cmd_m_size, cmd_n_size, cmd_l_size;
    logic             cmd_acc_clr, cmd_wb, cmd_last;

    sa_tile_scheduler #(.P(P), .Q(Q), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_l(cfg_l),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m_off(cmd_m_off), .cmd_n_off(cmd_n_off), .cmd_l_off(cmd_l_off),
        .cmd_m_size(cmd_m_size), .cmd_n_size(cmd_n_size), .cmd_l_size(cmd_l_size),
        .cmd_acc_clr(cmd_acc_clr), .cmd_wb(cmd_wb), .cmd_last(cmd_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] mo, no, lo, ms, ns, ls;
        logic       clr, wb, last;
    } cmd_t;

    cmd_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_hs_cyc = -100;
    bit   busy_window = 1'b0;
    int   busy_bad = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Closed-form balanced partition of d into ceil(d/lim) tiles.
    function automatic int tiles(input int d, input int lim);
        return (d + lim - 1) / lim;
    endfunction

    function automatic void part(input int d, input int lim, input int i,
                                 output int off, output int sz);
        int c, b, r;
        c   = tiles(d, lim);
        b   = d / c;
        r   = d % c;
        sz  = b + ((i < r) ? 1 : 0);
        off = i * b + ((i < r) ? i : r);
    endfunction

    // Push the whole expected command stream of one job; returns its length.
    function automatic int model_job(input int m, input int n, input int l);
        int   cm, cn, cl, om, sm, on, sn, ol, sl;
        cmd_t e;
        cm = tiles(m, P);
        cn = tiles(n, P);
        cl = tiles(l, Q);
        for (int im = 0; im < cm; im++) begin
            for (int il = 0; il < cl; il++) begin
                for (int in = 0; in < cn; in++) begin
                    part(m, P, im, om, sm);
                    part(l, Q, il, ol, sl);
                    part(n, P, in, on, sn);
                    e.mo   = 8'(om); e.no = 8'(on); e.lo = 8'(ol);
                    e.ms   = 8'(sm); e.ns = 8'(sn); e.ls = 8'(sl);
                    e.clr  = (in == 0);
                    e.wb   = (in == cn - 1);
                    e.last = (im == cm - 1) && (il == cl - 1) && (in == cn - 1);
                    exp_q.push_back(e);
                end
            end
        end
        return cm * cn * cl;
    endfunction

    // Monitor: scoreboard pop on handshake, hold check, done timing, busy.
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_rst   = 1'b1;
    cmd_t prev_act   = '0;

    always @(negedge clk) begin : mon
        cmd_t act;
        cmd_t e;
        act = {cmd_m_off, cmd_n_off, cmd_l_off, cmd_m_size, cmd_n_size,
               cmd_l_size, cmd_acc_clr, cmd_wb, cmd_last};
        if (!rst) begin
            if (prev_valid && !prev_ready && !prev_rst) begin
                n_cmp++;
                if (!(cmd_valid && act == prev_act)) begin
                    n_err++;
                    $display("FAIL hold: valid=%0b payload=%h required valid=1 payload=%h",
                             cmd_valid, act, prev_act);
                end
            end
            if (cmd_valid && cmd_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_cmd: got %h, required no command", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL cmd#%0d: got %h required %h", hs_cnt + 1, act, e);
                    end
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                n_cmp++;
                if (cyc != last_hs_cyc + 1 || cmd_valid || exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL done: cycles_after_hs=%0d valid=%0b pending=%0d required 1/0/0",
                             cyc - last_hs_cyc, cmd_valid, exp_q.size());
                end
                done_cnt++;
                busy_window = 1'b0;
            end else if (busy_window && !busy) begin
                busy_bad++;
            end
        end
        prev_valid = cmd_valid;
        prev_ready = cmd_ready;
        prev_rst   = rst;
        prev_act   = act;
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // Run one job. stall_at>0 holds ready low for stall_len cycles while
    // command stall_at is offered; rst_after>0 resets after that many handshakes.
    task automatic run_job(input int m, input int n, input int l,
                           input int stall_at, input int stall_len,
                           input int rst_after, input bit rnd);
        int total, base_hs, base_done, budget, left;
        total     = model_job(m, n, l);
        base_hs   = hs_cnt;
        base_done = done_cnt;
        busy_bad  = 0;
        left      = stall_len;
        budget    = 0;
        @(posedge clk); #1;
        cfg_m = 8'(m); cfg_n = 8'(n); cfg_l = 8'(l);
        start = 1'b1;
        cmd_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_m = 8'($urandom); cfg_n = 8'($urandom); cfg_l = 8'($urandom);
        busy_window = 1'b1;
        while (done_cnt == base_done && budget < 20000) begin
            if (rst_after > 0 && hs_cnt - base_hs == rst_after) begin
                rst = 1'b1;
                start = 1'b0;
                cmd_ready = 1'b0;
                busy_window = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_valid", int'(cmd_valid), 0);
                check("rst_busy", int'(busy), 0);
                exp_q.delete();
                return;
            end
            if (stall_at > 0 && hs_cnt - base_hs == stall_at - 1 && left > 0) begin
                cmd_ready = 1'b0;
                left--;
            end else begin
                cmd_ready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
            if (rnd && $urandom_range(7, 0) == 0) begin
                start = 1'b1;
                cfg_m = 8'($urandom); cfg_n = 8'($urandom); cfg_l = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        if (done_cnt == base_done) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: job %0d/%0d/%0d got %0d cmds required %0d then done",
                     m, n, l, hs_cnt - base_hs, total);
            exp_q.delete();
            busy_window = 1'b0;
        end else begin
            check("cmd_count", hs_cnt - base_hs, total);
            check("busy_during_job", busy_bad, 0);
            @(negedge clk);
            check("busy_after_done", int'(busy), 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              int'({busy, done, cfg_err, cmd_valid, cmd_acc_clr, cmd_wb, cmd_last}), 0);
        check("reset_payload",
              int'(|{cmd_m_off, cmd_n_off, cmd_l_off, cmd_m_size, cmd_n_size, cmd_l_size}), 0);

        run_job(25, 19, 17, 0, 0, 0, 1'b0);
        run_job(8, 8, 8, 0, 0, 0, 1'b0);
        run_job(1, 1, 1, 0, 0, 0, 1'b0);
        run_job(25, 19, 17, 4, 5, 0, 1'b0);

        // Zero dimension: error pulse only.
        @(posedge clk); #1;
        cfg_m = 8'd5; cfg_n = 8'd0; cfg_l = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", int'(cfg_err), 1);
        check("cfg_err_quiet", int'({busy, cmd_valid, done}), 0);
        @(negedge clk);
        check("cfg_err_clear", int'({cfg_err, busy, cmd_valid, done}), 0);
        run_job(3, 9, 2, 0, 0, 0, 1'b0);

        run_job(25, 19, 17, 0, 0, 10, 1'b0);
        run_job(25, 19, 17, 0, 0, 0, 1'b0);

        run_job(255, 9, 16, 0, 0, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            run_job($urandom_range(40, 1), $urandom_range(40, 1),
                    $urandom_range(40, 1), 0, 0, 0, 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
